// File: rtl/dram_banked_mp.sv
// dram_banked_mp -- word-interleaved, multi-lane banked data memory for the
// dual-issue MEM stage.
//
// A request group carries one access per lane. Accesses to different banks
// are served on the same edge; accesses that collide in a bank are served one
// per edge in lane-index order, so the visible result always equals executing
// lane 0 .. lane N-1 sequentially.
//
// Ports
//   CLK, RST         clock (posedge) and asynchronous active-high reset
//   req_valid_i      request group present
//   req_ready_o      group accepted on a posedge where req_valid_i && req_ready_o
//   lane_cs_i        per-lane enable (0 = lane idle)
//   lane_we_i        per-lane 1 = write, 0 = read
//   lane_addr_i      per-lane byte address (32 bits each, [1:0] ignored)
//   lane_be_i        per-lane write byte enables (4 bits each)
//   lane_wdata_i     per-lane write data
//   lane_bypass_i    per-lane forwarded write data
//   lane_dsrc_i      per-lane write-data select (1 = bypass, 0 = wdata)
//   rsp_valid_o      one-cycle pulse when a group completes
//   rsp_rdata_o      per-lane read data, held until the next completion
//   busy_o           group in flight
module dram_banked_mp #(
  parameter int NUM_LANES = 2,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 12
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [NUM_LANES-1:0]    lane_cs_i,
  input  logic [NUM_LANES-1:0]    lane_we_i,
  input  logic [32*NUM_LANES-1:0] lane_addr_i,
  input  logic [4*NUM_LANES-1:0]  lane_be_i,
  input  logic [32*NUM_LANES-1:0] lane_wdata_i,
  input  logic [32*NUM_LANES-1:0] lane_bypass_i,
  input  logic [NUM_LANES-1:0]    lane_dsrc_i,
  output logic                    rsp_valid_o,
  output logic [32*NUM_LANES-1:0] rsp_rdata_o,
  output logic                    busy_o
);

  localparam int BANK_LG = $clog2(NUM_BANKS);
  localparam int BANK_W  = (BANK_LG > 0) ? BANK_LG : 1;
  localparam int ROWS    = (2 ** ADDR_W) / NUM_BANKS;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                          state_q, state_d;
  logic [NUM_LANES-1:0]            pending_q, pending_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic [NUM_LANES-1:0][31:0]      rsp_rdata_q, rsp_rdata_d;

  // Captured group payload; only meaningful while pending bits are set.
  logic [NUM_LANES-1:0]            we_q;
  logic [NUM_LANES-1:0][ADDR_W-1:0] word_q;
  logic [NUM_LANES-1:0][3:0]       be_q;
  logic [NUM_LANES-1:0][31:0]      wdata_q;
  // Read results gathered during ISSUE, published together on completion.
  logic [NUM_LANES-1:0][31:0]      stage_q, stage_d;

  logic                            accept;
  logic                            done;
  logic [NUM_LANES-1:0]            grant;
  logic [NUM_LANES-1:0][BANK_W-1:0] lane_bank;
  logic [NUM_LANES-1:0][ROW_W-1:0] lane_row;
  logic [NUM_LANES-1:0][31:0]      lane_rd;
  logic [NUM_BANKS-1:0][31:0]      bank_rdata;

  // Address bits above the word index and the byte offset alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^lane_addr_i;

  assign accept = (state_q == IDLE) && req_valid_i;

  genvar gi;

  for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign lane_bank[gi] = BANK_W'(word_q[gi] & ADDR_W'(NUM_BANKS - 1));
    assign lane_row[gi]  = ROW_W'(word_q[gi] >> BANK_LG);
    assign lane_rd[gi]   = bank_rdata[lane_bank[gi]];
  end

  // A pending lane is granted unless a lower-index pending lane targets the
  // same bank; this yields at most one grant per bank, lowest lane first.
  always_comb begin
    grant = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      grant[l] = (state_q == ISSUE) && pending_q[l];
      for (int j = 0; j < l; j++) begin
        if (pending_q[j] && (lane_bank[j] == lane_bank[l])) begin
          grant[l] = 1'b0;
        end
      end
    end
  end

  for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [31:0]      mem [ROWS];
    logic             wr_en;
    logic [ROW_W-1:0] row;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    // Route the (single) granted lane of this bank onto its port.
    always_comb begin
      wr_en   = 1'b0;
      row     = '0;
      wr_be   = '0;
      wr_data = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (grant[l] && (lane_bank[l] == BANK_W'(gi))) begin
          wr_en   = we_q[l];
          row     = lane_row[l];
          wr_be   = be_q[l];
          wr_data = wdata_q[l];
        end
      end
    end

    // Array contents survive reset; a reset clears the grants instead.
    always_ff @(posedge CLK) begin
      if (wr_en) begin
        for (int k = 0; k < 4; k++) begin
          if (wr_be[k]) begin
            mem[row][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end
    end

    assign bank_rdata[gi] = mem[row];
  end

  // Next-state and response logic.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    rsp_valid_d = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d   = ISSUE;
          pending_d = lane_cs_i;
        end
      end
      ISSUE: begin
        pending_d = pending_q & ~grant;
        if (pending_d == '0) begin
          done        = 1'b1;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle and write lanes keep the zero loaded at accept.
  always_comb begin
    stage_d = stage_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (accept) begin
        stage_d[l] = '0;
      end else if (grant[l] && !we_q[l]) begin
        stage_d[l] = lane_rd[l];
      end
    end
    rsp_rdata_d = done ? stage_d : rsp_rdata_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Payload registers need no reset: they are reloaded on every accept and
  // ignored while no lane is pending.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        we_q[l]    <= lane_we_i[l];
        word_q[l]  <= lane_addr_i[32*l + 2 +: ADDR_W];
        be_q[l]    <= lane_be_i[4*l +: 4];
        wdata_q[l] <= lane_dsrc_i[l] ? lane_bypass_i[32*l +: 32]
                                     : lane_wdata_i[32*l +: 32];
      end
    end
    stage_q <= stage_d;
  end

  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == ISSUE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
